// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter. Grants are held for a whole cyc,
// with a fairness retry cap and a watchdog that aborts stalled accesses.
//   state | meaning
//   IDLE  | no owner; arbitrate among requesting masters
//   OWN0  | master 0 owns the slave until it drops cyc
//   OWN1  | master 1 owns the slave until it drops cyc
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ACKS   = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic [1:0]            grant_o
);

  localparam logic [7:0] LP_MAX     = 8'(MAX_ACKS);
  localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t     r_state;
  logic       r_last_owner;
  logic [7:0] r_ack_cnt;
  logic [7:0] r_wd_cnt;
  logic       r_force_rty;
  logic       r_rty_sent;
  logic       r_wd_abort;

  logic       w_own0, w_own1, w_owned;
  logic       w_cyc, w_stb, w_other_cyc;
  logic       w_any_resp, w_resp_ok;
  logic       w_ack, w_err, w_rty;
  logic       w_wd_fire, w_rty_pulse;
  logic [7:0] w_ack_cnt_nxt;

  assign w_own0      = (r_state == OWN0);
  assign w_own1      = (r_state == OWN1);
  assign w_owned     = w_own0 | w_own1;
  assign w_cyc       = w_own1 ? m1_cyc_i : (w_own0 & m0_cyc_i);
  assign w_stb       = w_own1 ? m1_stb_i : (w_own0 & m0_stb_i);
  assign w_other_cyc = w_own0 ? m1_cyc_i : (w_own1 & m0_cyc_i);

  assign s_cyc_o = w_cyc & ~r_wd_abort;
  assign s_stb_o = w_stb & ~r_force_rty & ~r_wd_abort;
  assign s_we_o  = w_own1 ? m1_we_i  : (w_own0 & m0_we_i);
  assign s_adr_o = w_own1 ? m1_adr_i : (w_own0 ? m0_adr_i : '0);
  assign s_dat_o = w_own1 ? m1_dat_i : (w_own0 ? m0_dat_i : '0);
  assign s_cti_o = w_own1 ? m1_cti_i : (w_own0 ? m0_cti_i : '0);
  assign s_bte_o = w_own1 ? m1_bte_i : (w_own0 ? m0_bte_i : '0);

  // Slave responses only reach the owner while a strobe can really be pending.
  assign w_any_resp  = s_ack_i | s_err_i | s_rty_i;
  assign w_resp_ok   = w_owned & ~r_force_rty & ~r_wd_abort;
  assign w_ack       = s_ack_i & w_resp_ok;
  assign w_wd_fire   = s_stb_o & ~w_any_resp & (r_wd_cnt == LP_WD_LAST);
  assign w_err       = (s_err_i & w_resp_ok) | w_wd_fire;
  assign w_rty_pulse = r_force_rty & w_stb & ~r_rty_sent;
  assign w_rty       = (s_rty_i & w_resp_ok) | w_rty_pulse;

  assign m0_ack_o = w_own0 & w_ack;
  assign m0_err_o = w_own0 & w_err;
  assign m0_rty_o = w_own0 & w_rty;
  assign m0_dat_o = w_own0 ? s_dat_i : '0;
  assign m1_ack_o = w_own1 & w_ack;
  assign m1_err_o = w_own1 & w_err;
  assign m1_rty_o = w_own1 & w_rty;
  assign m1_dat_o = w_own1 ? s_dat_i : '0;
  assign grant_o  = {w_own1, w_own0};

  assign w_ack_cnt_nxt = (w_ack && w_other_cyc && (r_ack_cnt != LP_MAX)) ?
                         r_ack_cnt + 8'd1 : r_ack_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_ack_cnt    <= 8'd0;
      r_wd_cnt     <= 8'd0;
      r_force_rty  <= 1'b0;
      r_rty_sent   <= 1'b0;
      r_wd_abort   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            r_ack_cnt   <= 8'd0;
            r_wd_cnt    <= 8'd0;
            r_force_rty <= 1'b0;
            r_rty_sent  <= 1'b0;
            r_wd_abort  <= 1'b0;
          end
          if (m0_cyc_i && (!m1_cyc_i || r_last_owner)) begin
            r_state      <= OWN0;
            r_last_owner <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state      <= OWN1;
            r_last_owner <= 1'b1;
          end
        end
        default: begin
          if (!w_cyc) begin
            r_state <= IDLE;
          end else begin
            r_ack_cnt <= w_ack_cnt_nxt;
            // Retry is armed only between transfers, never under a live strobe.
            if (!r_force_rty && (w_ack_cnt_nxt == LP_MAX) && (!s_stb_o || s_ack_i))
              r_force_rty <= 1'b1;
            if (w_rty_pulse)
              r_rty_sent <= 1'b1;
            if (s_stb_o && !w_any_resp) begin
              if (w_wd_fire) r_wd_abort <= 1'b1;
              else           r_wd_cnt   <= r_wd_cnt + 8'd1;
            end else begin
              r_wd_cnt <= 8'd0;
            end
          end
        end
      endcase
    end
  end

endmodule
